score_update_arbiter: RTL and testbench

- Shares the single 8-bit scoreUpdate input of the score display block between NUM_REQ point-award sources (alien hits, UFO hit, level bonus).
- Buffers one accumulated award per source and issues at most one award per video frame, in round-robin order.
- Watches the running score and pulses extraLife each time a BONUS_STEP boundary is crossed.
- Sits between the game-logic collision blocks and the score block.

---
 rtl/score_update_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_score_update_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_update_arbiter.sv
// score_update_arbiter
// Funnels point awards from several game-logic sources into the single 8-bit
// scoreUpdate port of the score block. Each source owns a one-entry slot that
// accumulates (saturating) until it is issued. At most one award is issued per
// video frame, in round-robin order. A bonus tracker watches the running score
// and pulses extraLife at every BONUS_STEP boundary.
module score_update_arbiter #(
  parameter int NUM_REQ    = 4,    // number of award sources (2..8)
  parameter int BONUS_STEP = 1500  // score interval between extra lives
) (
  input  logic                 clk,
  input  logic                 resetN,        // asynchronous, active-high
  input  logic                 startOfFrame,
  input  logic                 startGame,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] reqValue,
  input  logic [31:0]          score,
  output logic [7:0]           scoreUpdate,
  output logic [2:0]           grantIdx,
  output logic [NUM_REQ-1:0]   pending,
  output logic                 saturated,
  output logic                 extraLife
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,   // nothing waiting
    ARMED,  // awards waiting, issue on the next frame pulse
    ISSUE   // the cycle in which scoreUpdate carries the award
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         slot_q [NUM_REQ];
  logic [7:0]         slot_d [NUM_REQ];
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [7:0]         score_update_q, score_update_d;
  logic [2:0]         grant_idx_q, grant_idx_d;
  logic               saturated_q, saturated_d;
  logic [31:0]        next_bonus_q, next_bonus_d;
  logic               extra_life_q, extra_life_d;

  // Grant search results
  logic               grant_found;
  logic [PTR_W-1:0]   grant_sel;
  logic [PTR_W-1:0]   scan_idx;
  logic               issue_go;

  // Working values for slot accumulation and bonus stepping
  logic [8:0]         slot_sum;
  logic [7:0]         req_val;
  logic [32:0]        bonus_sum;

  // Round-robin search: first pending slot starting at rr_ptr, wrapping.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    grant_found = 1'b0;
    grant_sel   = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_found && pending_q[scan_idx]) begin
        grant_found = 1'b1;
        grant_sel   = scan_idx;
      end
    end
  end

  // A grant is taken only from ARMED on a frame pulse; startGame overrides it.
  assign issue_go = (state_q == ARMED) && startOfFrame && grant_found && !startGame;

  // Next-state logic for the FSM, slots, pending flags and issue register.
  always_comb begin
    state_d        = state_q;
    pending_d      = pending_q;
    rr_ptr_d       = rr_ptr_q;
    score_update_d = '0;
    grant_idx_d    = grant_idx_q;
    saturated_d    = saturated_q;
    slot_sum       = '0;
    req_val        = '0;
    for (int i = 0; i < NUM_REQ; i++) slot_d[i] = slot_q[i];

    if (startGame) begin
      // Restart wins over everything, including same-cycle requests.
      state_d     = IDLE;
      pending_d   = '0;
      rr_ptr_d    = '0;
      saturated_d = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) slot_d[i] = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|pending_q) state_d = ARMED;
        end
        ARMED: begin
          if (issue_go) begin
            state_d              = ISSUE;
            score_update_d       = slot_q[grant_sel];
            grant_idx_d          = 3'(grant_sel);
            slot_d[grant_sel]    = '0;
            pending_d[grant_sel] = 1'b0;
            rr_ptr_d             = PTR_W'((int'(grant_sel) + 1) % NUM_REQ);
          end
        end
        ISSUE: begin
          // Only one award per frame: a frame pulse seen here is ignored.
          state_d = (|pending_q) ? ARMED : IDLE;
        end
        default: state_d = IDLE;
      endcase

      // Capture new awards. A request that lands on the slot being issued
      // reloads it, since its previous contents have just been sent.
      for (int i = 0; i < NUM_REQ; i++) begin
        req_val = reqValue[8*i +: 8];
        if (req[i] && (req_val != 8'd0)) begin
          if (issue_go && (grant_sel == PTR_W'(i))) begin
            slot_d[i] = req_val;
          end else begin
            slot_sum = {1'b0, slot_q[i]} + {1'b0, req_val};
            if (slot_sum[8]) begin
              slot_d[i]   = 8'hFF;
              saturated_d = 1'b1;
            end else begin
              slot_d[i] = slot_sum[7:0];
            end
          end
          pending_d[i] = 1'b1;
        end
      end
    end
  end

  // Bonus tracker: one BONUS_STEP per cycle while the score is at or past it.
  always_comb begin
    next_bonus_d = next_bonus_q;
    extra_life_d = 1'b0;
    bonus_sum    = {1'b0, next_bonus_q} + 33'(BONUS_STEP);
    if (startGame) begin
      next_bonus_d = 32'(BONUS_STEP);
    end else if ((score >= next_bonus_q) && (next_bonus_q != 32'hFFFF_FFFF)) begin
      extra_life_d = 1'b1;
      next_bonus_d = bonus_sum[32] ? 32'hFFFF_FFFF : bonus_sum[31:0];
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      state_q        <= IDLE;
      pending_q      <= '0;
      rr_ptr_q       <= '0;
      score_update_q <= '0;
      grant_idx_q    <= '0;
      saturated_q    <= 1'b0;
      next_bonus_q   <= 32'(BONUS_STEP);
      extra_life_q   <= 1'b0;
      // NOTE: the slots are a handful of flops, not a RAM, so they are reset
      // along with everything else; an unreset slot would leak a stale award.
      for (int i = 0; i < NUM_REQ; i++) slot_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, regardless of statement order.
      state_q        <= state_d;
      pending_q      <= pending_d;
      rr_ptr_q       <= rr_ptr_d;
      score_update_q <= score_update_d;
      grant_idx_q    <= grant_idx_d;
      saturated_q    <= saturated_d;
      next_bonus_q   <= next_bonus_d;
      extra_life_q   <= extra_life_d;
      for (int i = 0; i < NUM_REQ; i++) slot_q[i] <= slot_d[i];
    end
  end

  // A restart arriving in the ISSUE cycle suppresses the award being shown.
  assign scoreUpdate = startGame ? 8'd0 : score_update_q;
  assign grantIdx    = grant_idx_q;
  assign pending     = pending_q;
  assign saturated   = saturated_q;
  assign extraLife   = extra_life_q;

endmodule

// File: tb/tb_score_update_arbiter.sv
// Testbench for score_update_arbiter: directed scenarios followed by random
// traffic, all compared against a behavioural model of the award rules.
module tb_score_update_arbiter;

  localparam int N    = 4;
  localparam int STEP = 1500;

  logic          clk = 1'b0;
  logic          resetN;
  logic          startOfFrame;
  logic          startGame;
  logic [N-1:0]  req;
  logic [8*N-1:0] reqValue;
  logic [31:0]   score;
  logic [7:0]    scoreUpdate;
  logic [2:0]    grantIdx;
  logic [N-1:0]  pending;
  logic          saturated;
  logic          extraLife;

  score_update_arbiter #(.NUM_REQ(N), .BONUS_STEP(STEP)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .startGame    (startGame),
    .req          (req),
    .reqValue     (reqValue),
    .score        (score),
    .scoreUpdate  (scoreUpdate),
    .grantIdx     (grantIdx),
    .pending      (pending),
    .saturated    (saturated),
    .extraLife    (extraLife)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Award slots, waiting flags, fairness pointer and bonus threshold.
  // A frame pulse is honoured when an award was already waiting at the start
  // of the previous cycle and that previous cycle was not itself an issue.
  int      m_slot [N];
  bit      m_pend [N];
  int      m_rr;
  longint  m_nb;
  int      m_su, m_gi;
  bit      m_sat, m_xl;
  bit      m_waited, m_last_served;
  logic [31:0] cur_score;

  function automatic logic [N-1:0] m_pend_vec();
    logic [N-1:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin m_slot[i] = 0; m_pend[i] = 0; end
    m_rr = 0; m_nb = STEP; m_su = 0; m_gi = 0; m_sat = 0; m_xl = 0;
    m_waited = 0; m_last_served = 0;
  endfunction

  function automatic void m_step(input bit sof, input bit sg, input logic [N-1:0] r,
                                 input logic [8*N-1:0] v, input logic [31:0] sc);
    bit any_now = (m_pend_vec() != '0);
    bit served;
    int g = -1;
    int val, sum;
    if (sg) begin
      for (int i = 0; i < N; i++) begin m_slot[i] = 0; m_pend[i] = 0; end
      m_rr = 0; m_nb = STEP; m_su = 0; m_sat = 0; m_xl = 0;
      m_waited = 0; m_last_served = 0;
      return;
    end
    served = sof && m_waited && !m_last_served;
    m_su = 0;
    if (served) begin
      for (int k = 0; k < N; k++)
        if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
      if (g >= 0) begin
        m_su = m_slot[g]; m_gi = g;
        m_slot[g] = 0; m_pend[g] = 0;
        m_rr = (g + 1) % N;
      end
    end
    for (int i = 0; i < N; i++) begin
      val = int'(v[8*i +: 8]);
      if (r[i] && val != 0) begin
        if (i == g) m_slot[i] = val;
        else begin
          sum = m_slot[i] + val;
          if (sum > 255) begin m_slot[i] = 255; m_sat = 1; end
          else m_slot[i] = sum;
        end
        m_pend[i] = 1;
      end
    end
    if (longint'(sc) >= m_nb && m_nb != 64'hFFFF_FFFF) begin
      m_xl = 1;
      m_nb = (m_nb + STEP > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_nb + STEP;
    end else m_xl = 0;
    m_waited = any_now;
    m_last_served = served && (g >= 0);
  endfunction

  // One clock cycle: apply inputs, check outputs, advance the model.
  task automatic tick(input bit sof, input bit sg, input logic [N-1:0] r, input logic [8*N-1:0] v);
    startOfFrame = sof; startGame = sg; req = r; reqValue = v; score = cur_score;
    #1;
    check("scoreUpdate", scoreUpdate, sg ? 0 : m_su);
    check("grantIdx", grantIdx, m_gi);
    check("pending", pending, m_pend_vec());
    check("saturated", saturated, m_sat);
    check("extraLife", extraLife, m_xl);
    @(posedge clk);
    m_step(sof, sg, r, v, cur_score);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, '0, '0);
  endtask

  function automatic logic [8*N-1:0] one_val(input int idx, input int val);
    logic [8*N-1:0] v = '0;
    v[8*idx +: 8] = 8'(val);
    return v;
  endfunction

  int pulses;

  initial begin
    resetN = 1'b1; startOfFrame = 0; startGame = 0; req = '0; reqValue = '0;
    cur_score = 0; score = 0;
    m_reset();
    #1;
    check("reset_scoreUpdate", scoreUpdate, 0);
    check("reset_pending", pending, 0);
    check("reset_extraLife", extraLife, 0);
    repeat (2) @(negedge clk);
    resetN = 1'b0;

    // Accumulate and saturate on slot 0: 200 + 100 clips to 255.
    tick(0, 0, 4'b0001, one_val(0, 200));
    tick(0, 0, 4'b0001, one_val(0, 100));
    idle(2);
    tick(1, 0, '0, '0);
    check("sat_value", scoreUpdate, 255);
    check("sat_flag", saturated, 1);
    idle(1);
    check("sat_single_cycle", scoreUpdate, 0);

    // Single award on slot 1.
    tick(0, 0, 4'b0010, one_val(1, 10));
    idle(2);
    check("single_pending", pending, 4'b0010);
    tick(1, 0, '0, '0);
    check("single_value", scoreUpdate, 10);
    check("single_grant", grantIdx, 1);
    check("single_cleared", pending, 0);
    idle(2);

    // Round-robin: pointer now at 2, all four slots loaded with 5,6,7,8.
    tick(0, 0, 4'b1111, {8'd8, 8'd7, 8'd6, 8'd5});
    idle(2);
    begin
      int exp_g [4] = '{2, 3, 0, 1};
      int exp_v [4] = '{7, 8, 5, 6};
      for (int f = 0; f < 4; f++) begin
        tick(1, 0, '0, '0);
        check("rr_grant", grantIdx, exp_g[f]);
        check("rr_value", scoreUpdate, exp_v[f]);
        idle(2);
      end
    end

    // Capture landing on the slot being issued (pointer at 2, slot 3 wins).
    tick(0, 0, 4'b1000, one_val(3, 20));
    idle(2);
    tick(1, 0, 4'b1000, one_val(3, 15));
    check("sim_value", scoreUpdate, 20);
    check("sim_grant", grantIdx, 3);
    check("sim_repending", pending, 4'b1000);
    idle(2);
    tick(1, 0, '0, '0);
    check("sim_reissue", scoreUpdate, 15);
    idle(2);

    // Bonus crossing 1490 -> 1510: one pulse.
    cur_score = 1490; idle(1);
    cur_score = 1510; tick(0, 0, '0, '0);
    check("bonus_pulse", extraLife, 1);
    idle(1);
    check("bonus_once", extraLife, 0);

    // startGame with two slots pending and threshold at 3000.
    tick(0, 0, 4'b0101, {8'd0, 8'd9, 8'd0, 8'd4});
    idle(2);
    cur_score = 0;
    tick(0, 1, '0, '0);
    check("restart_pending", pending, 0);
    idle(1);
    tick(1, 0, '0, '0);
    check("restart_no_award", scoreUpdate, 0);
    // Threshold is back at 1500: a jump to 4600 yields three pulses.
    cur_score = 4600;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick(0, 0, '0, '0);
      if (extraLife) pulses++;
    end
    check("bonus_jump_pulses", pulses, 3);

    // startGame in the ISSUE cycle suppresses the award.
    tick(0, 0, 4'b0100, one_val(2, 33));
    idle(2);
    tick(1, 0, '0, '0);
    check("issue_visible", scoreUpdate, 33);
    startGame = 1'b1;
    #1;
    check("restart_in_issue", scoreUpdate, 0);
    tick(0, 1, '0, '0);
    idle(1);

    // Reset asserted in the ISSUE cycle clears the award immediately.
    tick(0, 0, 4'b0001, one_val(0, 44));
    idle(2);
    tick(1, 0, '0, '0);
    check("pre_reset_award", scoreUpdate, 44);
    #2 resetN = 1'b1;
    #1;
    check("reset_in_issue", scoreUpdate, 0);
    check("reset_in_issue_pending", pending, 0);
    @(negedge clk);
    resetN = 1'b0;
    m_reset();
    cur_score = 0;
    idle(1);

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      logic [N-1:0]   r;
      logic [8*N-1:0] v;
      bit sof, sg;
      for (int i = 0; i < N; i++) begin
        r[i] = ($urandom_range(0, 3) == 0);
        v[8*i +: 8] = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      end
      sof = ($urandom_range(0, 3) == 0);
      sg  = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 49) == 0) cur_score = cur_score + $urandom_range(0, 6000);
      else cur_score = cur_score + $urandom_range(0, 40);
      if (sg && $urandom_range(0, 1) == 0) cur_score = 0;
      tick(sof, sg, r, v);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
